// File: rtl/interrupt_sequencer_if.sv
// Handshake bundle between the interrupt latch / control unit and the
// interrupt sequencer. The sequencer side uses the master modport; the
// latch/control-unit side (or a testbench) uses the slave modport.
interface interrupt_sequencer_if #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3,
  parameter int VEC_W   = 16
);
  logic [NUM_SRC-1:0] hardware;   // pending lines from the latch
  logic [NUM_SRC-1:0] irq_mask;   // per-source enable
  logic               irq_en;     // global enable
  logic               irq;        // request to control unit
  logic [ID_W-1:0]    irq_id;     // requested / in-service source
  logic [VEC_W-1:0]   irq_vector; // vector address of irq_id
  logic               irq_ack;    // control unit accepts (pulse)
  logic               irq_done;   // handler finished (pulse)
  logic [ID_W:0]      clr_input;  // {valid, id} latch clear code
  logic               busy;       // sequencer not idle

  modport master (
    input  hardware, irq_mask, irq_en, irq_ack, irq_done,
    output irq, irq_id, irq_vector, clr_input, busy
  );

  modport slave (
    output hardware, irq_mask, irq_en, irq_ack, irq_done,
    input  irq, irq_id, irq_vector, clr_input, busy
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: fixed-priority arbitration of latched interrupt lines
// (bit 0 highest) and a one-at-a-time IRQ/ACK/DONE handshake with the control
// unit. Each accepted request produces exactly one latch clear code.

// One arbitration lane: a source is eligible when pending, unmasked and
// globally enabled; it is granted only if no higher-priority lane is eligible.
module interrupt_sequencer_lane (
  input  logic i_pend,
  input  logic i_mask,
  input  logic i_en,
  input  logic i_higher,   // some higher-priority lane is eligible
  output logic o_any,      // this lane or a higher one is eligible
  output logic o_grant
);
  logic w_elig;

  assign w_elig  = i_pend & i_mask & i_en;
  assign o_grant = w_elig & ~i_higher;
  assign o_any   = w_elig | i_higher;
endmodule

module interrupt_sequencer #(
  parameter int               NUM_SRC    = 8,
  parameter int               ID_W       = 3,
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE   = 16'h0040,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 16'h0004
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  interrupt_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_CLEAR   = 2'd2;
  localparam logic [1:0] S_SERVICE = 2'd3;

  logic [1:0]         r_state;
  logic               r_irq;
  logic [ID_W-1:0]    r_id;
  logic [VEC_W-1:0]   r_vector;
  logic [ID_W:0]      r_clr;
  logic               r_busy;
  logic               r_done_pend;  // DONE seen during the CLEAR cycle

  logic [NUM_SRC:0]   w_chain;      // w_chain[i]: some lane below i is eligible
  logic [NUM_SRC-1:0] w_grant;      // one-hot winner
  logic [ID_W-1:0]    w_win_id;
  logic [VEC_W-1:0]   w_win_vec;
  logic               w_any;
  logic               w_req_live;

  // Priority chain: lane 0 sees no higher-priority competitor.
  assign w_chain[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
      interrupt_sequencer_lane u_lane (
        .i_pend   (bus.hardware[gi]),
        .i_mask   (bus.irq_mask[gi]),
        .i_en     (bus.irq_en),
        .i_higher (w_chain[gi]),
        .o_any    (w_chain[gi+1]),
        .o_grant  (w_grant[gi])
      );
    end
  endgenerate

  assign w_any = w_chain[NUM_SRC];

  // Encode the one-hot grant into a source ID.
  always_comb begin
    w_win_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) w_win_id = w_win_id | ID_W'(i);
    end
  end

  // Vector wraps modulo 2^VEC_W by construction of the sized arithmetic.
  assign w_win_vec  = VEC_BASE + (VEC_W'(w_win_id) * VEC_STRIDE);

  // The pending line of the source currently being requested.
  assign w_req_live = bus.hardware[r_id];

  // Handshake FSM; every output is a register updated here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_irq       <= 1'b0;
      r_id        <= '0;
      r_vector    <= VEC_BASE;
      r_clr       <= '0;
      r_busy      <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // ID/vector keep their last value while nothing is eligible.
          if (w_any) begin
            r_state  <= S_REQ;
            r_irq    <= 1'b1;
            r_id     <= w_win_id;
            r_vector <= w_win_vec;
            r_busy   <= 1'b1;
          end
        end
        S_REQ: begin
          // ACK beats a simultaneous withdrawal; mask/enable are not looked at.
          if (bus.irq_ack) begin
            r_state <= S_CLEAR;
            r_irq   <= 1'b0;
            r_clr   <= {1'b1, r_id};
          end else if (!w_req_live) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_CLEAR: begin
          // Clear code lives for exactly this cycle; remember an early DONE.
          r_state     <= S_SERVICE;
          r_clr       <= '0;
          r_done_pend <= bus.irq_done;
        end
        S_SERVICE: begin
          if (bus.irq_done || r_done_pend) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done_pend <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_irq       <= 1'b0;
          r_clr       <= '0;
          r_busy      <= 1'b0;
          r_done_pend <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq        = r_irq;
  assign bus.irq_id     = r_id;
  assign bus.irq_vector = r_vector;
  assign bus.clr_input  = r_clr;
  assign bus.busy       = r_busy;

  // Structural invariants of the handshake.
  a_irq_only_in_req: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) r_irq == (r_state == S_REQ));
  a_clr_only_in_clear: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) r_clr[ID_W] == (r_state == S_CLEAR));
  a_busy_not_idle: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) r_busy == (r_state != S_IDLE));

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: a reference model predicts the registered
// outputs every cycle into a queue, a monitor pops and compares them, and
// directed sequences plus a random phase drive the inputs.
module tb_interrupt_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic        irq;
    logic [2:0]  id;
    logic [15:0] vec;
    logic [3:0]  clr;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   clr_cnt[8];

  // Interrupt latch stand-in: set by stimulus, cleared by the DUT clear code
  // or by stimulus withdrawing a line.
  logic [7:0] lat;
  logic [7:0] set_bits = 8'h00;
  logic [7:0] drop_bits = 8'h00;
  logic [7:0] w_clrm;

  assign w_clrm = bus.clr_input[3] ? (8'h01 << bus.clr_input[2:0]) : 8'h00;

  always @(posedge clk) begin
    if (!rst_n) lat <= 8'h00;
    else        lat <= (lat | set_bits) & ~drop_bits & ~w_clrm;
  end

  assign bus.hardware = lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: phase of the transaction plus the selected source.
  initial begin : model_p
    int         ph;
    logic [2:0] id;
    bit         dpend;
    logic [7:0] el;
    logic [7:0] lowest;
    exp_t       e;
    ph = 0; id = 3'd0; dpend = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ph = 0; id = 3'd0; dpend = 1'b0;
      end else begin
        case (ph)
          0: begin
            el = bus.irq_en ? (bus.hardware & bus.irq_mask) : 8'h00;
            if (el != 8'h00) begin
              lowest = el & (~el + 8'd1);
              id     = 3'($countones(lowest - 8'd1));
              ph     = 1;
            end
          end
          1: begin
            if (bus.irq_ack) ph = 2;
            else if (!bus.hardware[id]) ph = 0;
          end
          2: begin
            dpend = bus.irq_done;
            ph    = 3;
          end
          default: begin
            if (bus.irq_done || dpend) begin
              ph = 0; dpend = 1'b0;
            end
          end
        endcase
      end
      e.irq  = (ph == 1);
      e.id   = id;
      e.vec  = 16'h0040 + 16'(id) * 16'h0004;
      e.clr  = (ph == 2) ? {1'b1, id} : 4'h0;
      e.busy = (ph != 0);
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every cycle's outputs against the model's prediction.
  initial begin : monitor_p
    exp_t e;
    exp_t act;
    for (int k = 0; k < 8; k++) clr_cnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      act = {bus.irq, bus.irq_id, bus.irq_vector, bus.clr_input, bus.busy};
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty @%0t: got %h expected a queued prediction", $time, act);
      end else begin
        e = exp_q.pop_front();
        chk("cycle{irq,id,vec,clr,busy}", act, e);
      end
      if (bus.clr_input[3]) clr_cnt[bus.clr_input[2:0]]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input logic [7:0] b);
    @(negedge clk); set_bits = b;
    @(negedge clk); set_bits = 8'h00;
  endtask

  task automatic drop(input logic [7:0] b);
    @(negedge clk); drop_bits = b;
    @(negedge clk); drop_bits = 8'h00;
  endtask

  task automatic pulse_ack();
    @(negedge clk); bus.irq_ack = 1'b1;
    @(negedge clk); bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); bus.irq_done = 1'b1;
    @(negedge clk); bus.irq_done = 1'b0;
  endtask

  task automatic wait_irq(input string nm, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (bus.irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin : stim_p
    int base[8];
    bus.irq_mask = 8'hFF;
    bus.irq_en   = 1'b1;
    bus.irq_ack  = 1'b0;
    bus.irq_done = 1'b0;

    // Reset values
    cyc(3);
    chk("reset_outputs", {bus.irq, bus.irq_id, bus.irq_vector, bus.clr_input, bus.busy},
        {1'b0, 3'd0, 16'h0040, 4'h0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    cyc(2);

    // Single source 4
    raise(8'h10);
    wait_irq("single_irq", 6);
    chk("single_id", 32'(bus.irq_id), 32'd4);
    chk("single_vec", 32'(bus.irq_vector), 32'h0050);
    pulse_ack();
    chk("single_clr", 32'(bus.clr_input), 32'hC);
    pulse_done();
    chk("single_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of SERVICE
    for (int k = 0; k < 8; k++) base[k] = clr_cnt[k];
    raise(8'h20);
    wait_irq("rst_irq", 6);
    pulse_ack();
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {bus.irq, bus.irq_id, bus.irq_vector, bus.clr_input, bus.busy},
        {1'b0, 3'd0, 16'h0040, 4'h0, 1'b0});
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    chk("rst_one_clear_only", 32'(clr_cnt[5] - base[5]), 32'd1);

    // Priority drain of 8'h7F
    for (int k = 0; k < 8; k++) base[k] = clr_cnt[k];
    raise(8'h7F);
    for (int k = 0; k < 7; k++) begin
      wait_irq("prio_irq", 8);
      chk("prio_id", 32'(bus.irq_id), 32'(k));
      pulse_ack();
      pulse_done();
    end
    cyc(3);
    for (int k = 0; k < 8; k++)
      chk("prio_clr_count", 32'(clr_cnt[k] - base[k]), (k < 7) ? 32'd1 : 32'd0);

    // Masking and global enable
    bus.irq_mask = 8'hFE;
    raise(8'h03);
    wait_irq("mask_irq", 6);
    chk("mask_id", 32'(bus.irq_id), 32'd1);
    pulse_ack();
    pulse_done();
    cyc(3);
    chk("mask_blocks_bit0", 32'(bus.irq), 32'd0);
    bus.irq_en   = 1'b0;
    bus.irq_mask = 8'hFF;
    cyc(4);
    chk("en_off_irq", 32'(bus.irq), 32'd0);
    chk("en_off_busy", 32'(bus.busy), 32'd0);
    drop(8'h01);
    bus.irq_en = 1'b1;
    cyc(2);

    // Withdraw without ACK, then withdraw together with ACK
    raise(8'h04);
    wait_irq("wd_irq", 6);
    chk("wd_id", 32'(bus.irq_id), 32'd2);
    drop(8'h04);
    @(posedge clk); #1;
    chk("wd_irq_low", 32'(bus.irq), 32'd0);
    chk("wd_no_clr", 32'(bus.clr_input), 32'd0);
    chk("wd_idle", 32'(bus.busy), 32'd0);
    raise(8'h04);
    wait_irq("wdack_irq", 6);
    @(negedge clk); drop_bits = 8'h04;
    @(negedge clk); drop_bits = 8'h00; bus.irq_ack = 1'b1;
    @(negedge clk); bus.irq_ack = 1'b0;
    chk("wdack_clr", 32'(bus.clr_input), 32'hA);
    pulse_done();
    cyc(2);

    // Stray handshakes and no nesting
    pulse_ack();
    pulse_done();
    chk("stray_idle_irq", 32'(bus.irq), 32'd0);
    chk("stray_idle_busy", 32'(bus.busy), 32'd0);
    raise(8'h08);
    wait_irq("stray_irq", 6);
    pulse_done();
    chk("stray_done_in_req", {bus.irq, bus.irq_id}, {1'b1, 3'd3});
    pulse_ack();
    raise(8'h01);
    cyc(3);
    chk("nest_held_irq", 32'(bus.irq), 32'd0);
    chk("nest_held_busy", 32'(bus.busy), 32'd1);
    pulse_done();
    wait_irq("nest_irq", 6);
    chk("nest_id", 32'(bus.irq_id), 32'd0);
    pulse_ack();
    bus.irq_done = 1'b1;          // DONE in the CLEAR cycle
    @(negedge clk); bus.irq_done = 1'b0;
    cyc(2);
    chk("early_done_busy", 32'(bus.busy), 32'd0);

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      set_bits     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      drop_bits    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      bus.irq_mask = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
      bus.irq_en   = ($urandom_range(0, 9) != 0);
      bus.irq_ack  = ($urandom_range(0, 2) == 0);
      bus.irq_done = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    set_bits = 8'h00; drop_bits = 8'h00;
    bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
